adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture_pkg.sv | 39 +++
 rtl/adc_capture_decim.sv | 30 +++
 rtl/adc_capture.sv | 135 +++++++++++++
 tb/tb_adc_capture.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC capture block: FSM encoding, buffer geometry
// and the EBI bank/register map through which the capture engine is driven.
package adc_capture_pkg;

    localparam int CAP_ADDR_W  = 12;
    localparam int CAP_WARMUP  = 8;
    localparam int CAP_DECIM_W = 8;
    localparam int SAMPLE_W    = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WARMUP  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // EBI chip-select banks; the capture buffer is mapped into its own bank
    localparam logic [3:0] EBI_BANK_REGS = 4'h0;
    localparam logic [3:0] EBI_BANK_BRAM = 4'h1;
    localparam logic [3:0] BRAM_BANK     = EBI_BANK_BRAM;

    typedef enum logic [7:0] {
        REG_CTRL   = 8'h00,
        REG_STATUS = 8'h04,
        REG_LEN    = 8'h08,
        REG_DECIM  = 8'h0C,
        REG_COUNT  = 8'h10
    } ebi_reg_e;

    typedef struct packed {
        logic abort;
        logic arm;
    } ebi_ctrl_t;

    typedef struct packed {
        logic of_sticky;
        logic done;
        logic busy;
    } ebi_status_t;

endpackage

// File: rtl/adc_capture_decim.sv
// Decimation counter: flags one sample out of every (decim+1) while enabled,
// starting with the first strobe after a clear.
module sample_decimator #(
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               clear,
    input  logic               en,
    input  logic               valid,
    input  logic [DECIM_W-1:0] decim,
    output logic               keep
);

    localparam logic [DECIM_W-1:0] CNT_ONE = 1;

    logic [DECIM_W-1:0] cnt_reg;

    // Combinational so the write can be registered one cycle after the strobe
    assign keep = en && valid && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg <= '0;
        end else if (en && valid) begin
            cnt_reg <= (cnt_reg == decim) ? '0 : cnt_reg + CNT_ONE;
        end
    end

endmodule

// File: rtl/adc_capture.sv
// ADC capture engine: powers up the converter, discards its pipeline warm-up
// samples, then writes decimated samples into a 16-bit-wide capture BRAM.
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W  = CAP_ADDR_W,
    parameter int WARMUP  = CAP_WARMUP,
    parameter int DECIM_W = CAP_DECIM_W
) (
    input  logic               clk_100M,
    input  logic               rst,
    input  logic [15:0]        adc_data,
    input  logic               adc_of,
    input  logic               adc_valid,
    input  logic               arm,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  cfg_len,
    input  logic [DECIM_W-1:0] cfg_decim,
    output logic               adc_clk_en,
    output logic               adc_noe,
    output logic [ADDR_W:0]    bram_addr,
    output logic [15:0]        bram_data,
    output logic               bram_we,
    output logic               busy,
    output logic               done,
    output logic               of_sticky,
    output logic [ADDR_W:0]    wr_count
);

    localparam int WU_W = $clog2(WARMUP + 1);
    localparam logic [WU_W-1:0]  WU_LAST = WU_W'(WARMUP - 1);
    localparam logic [WU_W-1:0]  WU_ONE  = 1;
    localparam logic [ADDR_W:0]  CNT_ONE = 1;

    logic [1:0]         state_reg;
    logic [ADDR_W-1:0]  len_reg;
    logic [DECIM_W-1:0] decim_reg;
    logic [WU_W-1:0]    wu_cnt_reg;
    logic [ADDR_W:0]    wr_count_reg;
    logic               of_reg;
    logic               we_reg;
    logic [ADDR_W:0]    addr_reg;
    logic [15:0]        data_reg;

    logic arm_ok;
    logic capturing;
    logic keep;
    logic last_write;

    // Abort outranks arm and also suppresses a write that would issue this cycle
    assign arm_ok     = arm && !abort && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign capturing  = (state_reg == ST_CAPTURE) && !abort;
    assign last_write = keep && (wr_count_reg[ADDR_W-1:0] == len_reg);

    sample_decimator #(
        .DECIM_W (DECIM_W)
    ) u_decim (
        .clk   (clk_100M),
        .srst  (rst),
        .clear (arm_ok),
        .en    (capturing),
        .valid (adc_valid),
        .decim (decim_reg),
        .keep  (keep)
    );

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            decim_reg    <= '0;
            wu_cnt_reg   <= '0;
            wr_count_reg <= '0;
            of_reg       <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            we_reg <= keep;
            if (keep) begin
                // Low ADDR_W bits of the write count are the word pointer
                addr_reg     <= {wr_count_reg[ADDR_W-1:0], 1'b0};
                data_reg     <= adc_data;
                wr_count_reg <= wr_count_reg + CNT_ONE;
                if (adc_of) begin
                    of_reg <= 1'b1;
                end
            end
            if (arm_ok) begin
                len_reg      <= cfg_len;
                decim_reg    <= cfg_decim;
                wu_cnt_reg   <= '0;
                wr_count_reg <= '0;
                of_reg       <= 1'b0;
            end

            if (abort) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state_reg <= ST_WARMUP;
                        end
                    end
                    ST_WARMUP: begin
                        if (adc_valid) begin
                            wu_cnt_reg <= wu_cnt_reg + WU_ONE;
                            if (wu_cnt_reg == WU_LAST) begin
                                state_reg <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (last_write) begin
                            state_reg <= ST_DONE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy       = (state_reg == ST_WARMUP) || (state_reg == ST_CAPTURE);
    assign done       = (state_reg == ST_DONE);
    assign adc_clk_en = busy;
    assign adc_noe    = !busy;
    assign bram_we    = we_reg;
    assign bram_addr  = addr_reg;
    assign bram_data  = data_reg;
    assign of_sticky  = of_reg;
    assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: expected writes are predicted from the
// sample stream when stimulus is issued and matched by a write monitor.
module tb_adc_capture;
    import adc_capture_pkg::*;

    localparam int AW = CAP_ADDR_W;
    localparam int WU = CAP_WARMUP;
    localparam int DW = CAP_DECIM_W;

    logic          clk_100M = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   adc_data = '0;
    logic          adc_of = 1'b0;
    logic          adc_valid = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] cfg_len = '0;
    logic [DW-1:0] cfg_decim = '0;
    logic          adc_clk_en, adc_noe, bram_we, busy, done, of_sticky;
    logic [AW:0]   bram_addr, wr_count;
    logic [15:0]   bram_data;

    adc_capture #(.ADDR_W(AW), .WARMUP(WU), .DECIM_W(DW)) dut (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .adc_data   (adc_data),
        .adc_of     (adc_of),
        .adc_valid  (adc_valid),
        .arm        (arm),
        .abort      (abort),
        .cfg_len    (cfg_len),
        .cfg_decim  (cfg_decim),
        .adc_clk_en (adc_clk_en),
        .adc_noe    (adc_noe),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .bram_we    (bram_we),
        .busy       (busy),
        .done       (done),
        .of_sticky  (of_sticky),
        .wr_count   (wr_count)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [AW:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  we_times[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    // Reference model: capture seen as "k-th sample after warm-up, keep every (decim+1)-th"
    bit m_active = 0, m_done = 0, m_of = 0;
    int m_idx = 0, m_stored = 0, m_len = 0, m_decim = 0;

    always @(posedge clk_100M) cyc <= cyc + 1;

    wr_t e;
    always @(negedge clk_100M) begin
        if (bram_we === 1'b1) begin
            we_times.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0h data=%0h, required no write", bram_addr, bram_data);
            end else begin
                e = exp_q.pop_front();
                if (bram_addr !== e.addr || bram_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write_content: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             bram_addr, bram_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_sample(input logic [15:0] d, input logic of);
        int k;
        wr_t w;
        if (!m_active) return;
        if (m_idx >= WU) begin
            k = m_idx - WU;
            if (k % (m_decim + 1) == 0) begin
                w.addr = (AW+1)'(m_stored * 2);
                w.data = d;
                exp_q.push_back(w);
                m_stored++;
                if (of) m_of = 1;
                if (m_stored == m_len + 1) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
        m_idx++;
    endtask

    task automatic sample(input logic [15:0] d, input logic of);
        adc_data  = d;
        adc_of    = of;
        adc_valid = 1'b1;
        model_sample(d, of);
        tick();
        adc_valid = 1'b0;
        adc_of    = 1'b0;
    endtask

    task automatic arm_cap(input int len, input int decim);
        cfg_len   = AW'(len);
        cfg_decim = DW'(decim);
        arm       = 1'b1;
        if (!m_active) begin
            m_active = 1; m_done = 0; m_of = 0;
            m_idx = 0; m_stored = 0; m_len = len; m_decim = decim;
        end
        tick();
        arm = 1'b0;
    endtask

    task automatic abort_cap(input bit with_arm);
        abort = 1'b1;
        arm   = with_arm;
        m_active = 0;
        m_done   = 0;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_active = 0; m_done = 0; m_of = 0; m_stored = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy"},       32'(busy),       32'(m_active));
        chk({tag, "_done"},       32'(done),       32'(m_done));
        chk({tag, "_wr_count"},   32'(wr_count),   32'(m_stored));
        chk({tag, "_of_sticky"},  32'(of_sticky),  32'(m_of));
        chk({tag, "_adc_noe"},    32'(adc_noe),    32'(!m_active));
        chk({tag, "_adc_clk_en"}, 32'(adc_clk_en), 32'(m_active));
    endtask

    task automatic drain(input string tag);
        idle(3);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int len, decim, n;
        idle(3);
        rst = 1'b0;
        chk("reset_bram_we",   32'(bram_we),   32'd0);
        chk("reset_bram_addr", 32'(bram_addr), 32'd0);
        chk("reset_bram_data", 32'(bram_data), 32'd0);
        check_status("reset");
        $display("txn reset: busy=%0d done=%0d noe=%0d", busy, done, adc_noe);

        // Basic capture, no decimation, data 0x1000..0x100B
        arm_cap(3, 0);
        chk("arm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < WU + 4; i++) sample(16'h1000 + 16'(i), 1'b0);
        drain("basic");
        check_status("basic");
        chk("basic_last_addr", 32'(bram_addr), 32'h6);
        chk("basic_last_data", 32'(bram_data), 32'h100B);
        $display("txn basic: wr_count=%0d done=%0d last_addr=%0h", wr_count, done, bram_addr);

        // Decimate by 3, continuous strobes
        arm_cap(1, 2);
        we_times.delete();
        for (int i = 0; i < WU + 8; i++) sample(16'h2000 + 16'(i), 1'b0);
        drain("decim");
        check_status("decim");
        chk("decim_we_count", 32'(we_times.size()), 32'd2);
        if (we_times.size() == 2)
            chk("decim_we_spacing", 32'(we_times[1] - we_times[0]), 32'd3);
        $display("txn decim: wr_count=%0d pulses=%0d", wr_count, we_times.size());

        // Overflow on a stored sample, then on a discarded one only
        arm_cap(2, 1);
        for (int i = 0; i < WU + 6; i++) sample(16'h3000 + 16'(i), i == WU + 2);
        drain("of_stored");
        chk("of_stored_flag", 32'(of_sticky), 32'd1);
        check_status("of_stored");
        arm_cap(2, 1);
        chk("of_rearm_clear", 32'(of_sticky), 32'd0);
        chk("rearm_wr_count", 32'(wr_count), 32'd0);
        for (int i = 0; i < WU + 6; i++) sample(16'h3100 + 16'(i), i == WU + 1);
        drain("of_skipped");
        check_status("of_skipped");
        $display("txn overflow: of_sticky=%0d", of_sticky);

        // Full-length capture
        arm_cap(4095, 0);
        we_times.delete();
        for (int i = 0; i < WU + 4096 + 3; i++) sample(16'($urandom), 1'b0);
        drain("full");
        check_status("full");
        chk("full_pulses", 32'(we_times.size()), 32'd4096);
        chk("full_last_addr", 32'(bram_addr), 32'h1FFE);
        chk("full_wr_count", 32'(wr_count), 32'd4096);
        $display("txn full: wr_count=%0d last_addr=%0h", wr_count, bram_addr);

        // Abort after two writes, then arm+abort together, then abort from DONE
        arm_cap(10, 0);
        we_times.delete();
        for (int i = 0; i < WU + 2; i++) sample(16'h4000 + 16'(i), 1'b0);
        idle(2);
        abort_cap(0);
        check_status("abort");
        for (int i = 0; i < 5; i++) sample(16'h4100 + 16'(i), 1'b0);
        drain("abort");
        chk("abort_pulses", 32'(we_times.size()), 32'd2);
        abort_cap(1);
        check_status("arm_abort");
        arm_cap(0, 0);
        for (int i = 0; i < WU + 1; i++) sample(16'h4200 + 16'(i), 1'b0);
        idle(1);
        chk("pre_abort_done", 32'(done), 32'd1);
        abort_cap(0);
        check_status("abort_done");
        drain("abort_done");
        $display("txn abort: busy=%0d done=%0d wr_count=%0d", busy, done, wr_count);

        // Ignored arm and cfg changes mid-capture, then reset mid-capture
        arm_cap(20, 1);
        for (int i = 0; i < WU + 6; i++) sample(16'h5000 + 16'(i), 1'b0);
        arm_cap(3, 0);
        cfg_len = '1; cfg_decim = '1;
        check_status("arm_ignored");
        for (int i = 0; i < 6; i++) sample(16'h5100 + 16'(i), 1'b0);
        idle(1);
        do_reset();
        chk("rst_bram_we",   32'(bram_we),   32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_data", 32'(bram_data), 32'd0);
        check_status("rst_mid");
        for (int i = 0; i < 4; i++) sample(16'h5200 + 16'(i), 1'b0);
        drain("rst_mid");
        $display("txn rst_mid: busy=%0d wr_count=%0d", busy, wr_count);

        // Randomized captures with gaps, overflow, stray arm and cfg changes
        for (int it = 0; it < 8; it++) begin
            len   = $urandom_range(0, 15);
            decim = $urandom_range(0, 3);
            arm_cap(len, decim);
            n = 0;
            while (m_active && n < 2000) begin
                if ($urandom_range(0, 3) != 0) sample(16'($urandom), $urandom_range(0, 7) == 0);
                else idle(1);
                if (n == 5) begin
                    cfg_len = AW'($urandom); cfg_decim = DW'($urandom);
                end
                if (n == 7) arm_cap($urandom_range(0, 15), 0);
                n++;
            end
            for (int i = 0; i < 3; i++) sample(16'($urandom), 1'b1);
            drain("rand");
            check_status("rand");
            $display("txn rand%0d: len=%0d decim=%0d wr_count=%0d of=%0d", it, len, decim, wr_count, of_sticky);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
